// File: rtl/sys_ctrl_pkg.sv
// Shared types and defaults for the system command controller.
// Holds the FSM state encoding and command code defaults.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    OP_A,
    OP_B,
    ALU_CMD,
    ALU_WAIT,
    ALU_SEND
  } state_t;

  localparam logic [7:0] CMD_WR_DEF      = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP_DEF  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP_DEF = 8'hDD;

  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// Splits a wide ALU result into bytes, LSB first.
// Holds the current chunk while the TX FIFO is full.
module resp_serializer #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [OUT_W-1:0]  load_data,
  input  logic              fifo_full,
  output logic              byte_vld,
  output logic [DATA_W-1:0] byte_out,
  output logic              done
);

  localparam int NB    = OUT_W / DATA_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [OUT_W-1:0] sreg_q;
  logic [IDX_W-1:0] idx_q;
  logic             active_q;
  logic             last;

  assign last     = (idx_q == IDX_W'(NB - 1));
  assign byte_vld = active_q & ~fifo_full;
  assign byte_out = sreg_q[DATA_W-1:0];
  assign done     = byte_vld & last;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      sreg_q   <= load_data;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (byte_vld) begin
      sreg_q   <= sreg_q >> DATA_W;
      idx_q    <= idx_q + IDX_W'(1);
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// UART command decoder driving register file, ALU and TX FIFO.
// All outputs are registered; strobes follow the accepted byte.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 16,
  parameter int FUN_W  = 4,
  parameter logic [DATA_W-1:0] CMD_WR =
    DATA_W'(CMD_WR_DEF),
  parameter logic [DATA_W-1:0] CMD_RD =
    DATA_W'(CMD_RD_DEF),
  parameter logic [DATA_W-1:0] CMD_ALU_OP =
    DATA_W'(CMD_ALU_OP_DEF),
  parameter logic [DATA_W-1:0] CMD_ALU_NOP =
    DATA_W'(CMD_ALU_NOP_DEF),
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [OUT_W-1:0]  ALU_OUT,
  input  logic              OUT_Valid,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic              fifo_full,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              EN,
  output logic              CLK_EN,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              clk_div_en,
  output logic              frame_err,
  output logic              busy
);

  localparam int TO_W = to_w(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic [FUN_W-1:0]  fun_d;
  logic              en_d;
  logic [ADDR_W-1:0] adr_d;
  logic              wr_d;
  logic              rdn_d;
  logic [DATA_W-1:0] wdat_d;
  logic [DATA_W-1:0] txd_d;
  logic              txv_d;
  logic              err_d;

  logic              timed;
  logic              evt;
  logic              ser_load;
  logic              ser_vld;
  logic              ser_done;
  logic [DATA_W-1:0] ser_byte;

  logic [ADDR_W-1:0] rx_addr;

  assign rx_addr = RX_P_DATA[ADDR_W-1:0];

  assign timed = state_q inside {
    WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OP_A, OP_B, ALU_CMD, ALU_WAIT
  };

  resp_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .load_data (ALU_OUT),
    .fifo_full (fifo_full),
    .byte_vld  (ser_vld),
    .byte_out  (ser_byte),
    .done      (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    fun_d    = '0;
    en_d     = 1'b0;
    adr_d    = '0;
    wr_d     = 1'b0;
    rdn_d    = 1'b0;
    wdat_d   = '0;
    txd_d    = '0;
    txv_d    = 1'b0;
    err_d    = 1'b0;
    ser_load = 1'b0;
    evt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          unique case (1'b1)
            (RX_P_DATA == CMD_WR):
              state_d = WR_ADDR;
            (RX_P_DATA == CMD_RD):
              state_d = RD_ADDR;
            (RX_P_DATA == CMD_ALU_OP):
              state_d = OP_A;
            (RX_P_DATA == CMD_ALU_NOP):
              state_d = ALU_CMD;
            default:
              err_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          addr_d  = rx_addr;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          wr_d    = 1'b1;
          adr_d   = addr_q;
          wdat_d  = RX_P_DATA;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          rdn_d   = 1'b1;
          adr_d   = rx_addr;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          evt     = 1'b1;
          rd_d    = RdData;
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (!fifo_full) begin
          txv_d   = 1'b1;
          txd_d   = rd_q;
          state_d = IDLE;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          wr_d    = 1'b1;
          adr_d   = ADDR_W'(OPA_ADDR);
          wdat_d  = RX_P_DATA;
          state_d = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          wr_d    = 1'b1;
          adr_d   = ADDR_W'(OPB_ADDR);
          wdat_d  = RX_P_DATA;
          state_d = ALU_CMD;
        end
      end
      ALU_CMD: begin
        if (RX_D_VLD) begin
          evt     = 1'b1;
          en_d    = 1'b1;
          fun_d   = RX_P_DATA[FUN_W-1:0];
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (OUT_Valid) begin
          evt      = 1'b1;
          ser_load = 1'b1;
          state_d  = ALU_SEND;
        end
      end
      ALU_SEND: begin
        if (ser_vld) begin
          txv_d = 1'b1;
          txd_d = ser_byte;
        end
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Wait counter only runs while a byte or reply is outstanding
    if (timed && !evt) begin
      if (cnt_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_FUN    <= '0;
      EN         <= 1'b0;
      CLK_EN     <= 1'b0;
      Address    <= '0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      WrData     <= '0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      clk_div_en <= 1'b1;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ALU_FUN    <= fun_d;
      EN         <= en_d;
      CLK_EN     <= state_d inside {ALU_CMD, ALU_WAIT};
      Address    <= adr_d;
      WrEn       <= wr_d;
      RdEn       <= rdn_d;
      WrData     <= wdat_d;
      TX_P_DATA  <= txd_d;
      TX_D_VLD   <= txv_d;
      clk_div_en <= 1'b1;
      frame_err  <= err_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Parametrised second-generation system controller. It decodes UART RX command frames into register-file writes and reads, and into ALU operations. Results go to the TX FIFO as a multi-byte response, with real backpressure on fifo_full and a per-frame inter-byte timeout. It sits between the UART RX/TX data paths, the register file, the gated ALU and the TX async FIFO, all in the reference clock domain.

Parameters:
DATA_W, 8, RX/TX/register data width
ADDR_W, 4, register file address width
OUT_W, 16, ALU result width; must be a multiple of DATA_W
FUN_W, 4, ALU function code width; must be at most DATA_W
CMD_WR, 8'hAA, register write command code
CMD_RD, 8'hBB, register read command code
CMD_ALU_OP, 8'hCC, ALU with operands command code
CMD_ALU_NOP, 8'hDD, ALU without operands command code
OPA_ADDR, 0, register address of operand A
OPB_ADDR, 1, register address of operand B
TIMEOUT, 1023, max cycles waited for the next byte, RdData_Valid or OUT_Valid; TO_W = clog2(TIMEOUT+1)

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_W  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_OUT  in  OUT_W  ALU result
OUT_Valid  in  1  ALU result valid
RdData  in  DATA_W  register file read data
RdData_Valid  in  1  read data valid
fifo_full  in  1  TX FIFO full
ALU_FUN  out  FUN_W  ALU function
EN  out  1  ALU enable strobe
CLK_EN  out  1  ALU clock-gate enable
Address  out  ADDR_W  register file address
WrEn  out  1  register write strobe
RdEn  out  1  register read strobe
WrData  out  DATA_W  register write data
TX_P_DATA  out  DATA_W  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
clk_div_en  out  1  clock divider enable
frame_err  out  1  one-cycle pulse on timeout or unknown command
busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- All outputs are registered. On reset every output is 0 except clk_div_en=1. State goes to IDLE; internal address, result and counter registers clear.
- clk_div_en is constant 1 outside reset.
- Byte acceptance:
  - A byte accepted in cycle N (RX_D_VLD=1) produces its strobe (WrEn/RdEn/EN) in cycle N+1, one cycle wide.
  - Address, WrData and ALU_FUN are valid in the same cycle as the strobe and are 0 otherwise.
- States and transitions:
  - IDLE:
    - CMD_WR -> WR_ADDR; CMD_RD -> RD_ADDR; CMD_ALU_OP -> OP_A; CMD_ALU_NOP -> ALU_CMD.
    - Any other byte: frame_err pulse, stay IDLE.
  - WR_ADDR: byte[ADDR_W-1:0] is latched -> WR_DATA.
  - WR_DATA: byte -> WrEn with latched Address -> IDLE.
  - RD_ADDR: byte -> RdEn, Address = byte[ADDR_W-1:0] -> RD_WAIT.
  - RD_WAIT: RdData_Valid latches RdData -> RD_SEND.
  - RD_SEND: the latched byte is emitted once fifo_full=0 -> IDLE.
  - OP_A: byte -> WrEn, Address=OPA_ADDR -> OP_B.
  - OP_B: byte -> WrEn, Address=OPB_ADDR -> ALU_CMD.
  - ALU_CMD: CLK_EN=1; byte -> EN, ALU_FUN = byte[FUN_W-1:0] -> ALU_WAIT.
  - ALU_WAIT: CLK_EN=1; OUT_Valid latches ALU_OUT into the result register -> ALU_SEND.
  - ALU_SEND: emits OUT_W/DATA_W bytes, LSB byte first, byte index counter, -> IDLE after the last byte.
- TX rules:
  - TX_D_VLD is asserted only in cycles where fifo_full=0 at the decision edge.
  - While fifo_full=1 the current byte is held; nothing is dropped, duplicated or reordered.
  - At most one byte per cycle; back-to-back bytes are allowed.
- Timeout:
  - A counter resets on every state entry and on every accepted event.
  - In WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_CMD and ALU_WAIT, reaching TIMEOUT gives a frame_err pulse -> IDLE, with no strobes issued.
  - The counter does not run in the SEND states; backpressure is unbounded.
- Simultaneous events: RX_D_VLD during RD_WAIT, ALU_WAIT or the SEND states is ignored. Bytes are not queued.
- Reset mid-operation aborts immediately. No partial TX or strobe appears after reset release.

Decomposition:
- Package sys_ctrl_pkg: state enum typedef, default command code localparams, the clog2-based TO_W helper.
- One sub-module, resp_serializer: loads OUT_W bits, emits DATA_W chunks LSB first under fifo_full backpressure, and flags done.

Test Plan:
- Write frame AA,05,3C -> single WrEn cycle with Address=5, WrData=3C. No TX_D_VLD. frame_err stays 0.
- Read frame BB,05; RdData=3C with RdData_Valid 2 cycles after RdEn -> RdEn pulse with Address=5, then one TX_D_VLD with TX_P_DATA=3C.
- ALU frame CC,07,03,00; ALU_OUT=000A with OUT_Valid -> WrEn at addr 0 (07) and addr 1 (03), EN with ALU_FUN=0, then TX bytes 0A then 00.
- Same ALU frame with fifo_full=1 for 3 cycles at the second byte -> TX_D_VLD low for exactly those cycles, then 00 emitted once.
- Byte AA then silence for TIMEOUT cycles -> one frame_err pulse, busy falls, no WrEn. A following AA,02,11 writes normally. Byte 55 in IDLE -> frame_err pulse.
- Assert RST during ALU_WAIT -> outputs at reset values, clk_div_en=1. No TX after release, even with OUT_Valid pending.
